exp_range_reduce: RTL and testbench

- Range-reduction stage directly downstream of the integer-select stage in the exp datapath.
- Takes the unsigned Q4.11 exponent argument x and the selected integer k, where k = max(1, floor(x/ln2)) for legal x and k = 0 for out-of-range x.
- Computes the signed residual r = x − k·ln2 so that e^x = 2^k · e^r, and forwards k and r to the residual-exponential evaluator.
- 2-stage pipeline with valid/ready handshake on both sides and full backpressure.

---
 rtl/exp_range_reduce_if.sv | 23 ++
 rtl/exp_range_reduce.sv | 86 ++++++++
 tb/tb_exp_range_reduce.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/exp_range_reduce_if.sv
// Handshake bundle between the integer-select stage, the range-reduction stage and
// the residual-exponential evaluator: (x, k) in, (k, r, ovf) out.
interface exp_range_reduce_if;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] in_data;
   logic [4:0]  in_k;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_k;
   logic [17:0] out_r;
   logic        out_ovf;

   modport master (
      output in_valid, in_data, in_k, out_ready,
      input  in_ready, out_valid, out_k, out_r, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_k, out_ready,
      output in_ready, out_valid, out_k, out_r, out_ovf
   );
endinterface

// File: rtl/exp_range_reduce.sv
// Exp range reduction: r = x - k*ln2 so that e^x = 2^k * e^r.
// Two-stage valid/ready pipeline with full backpressure; no comb path from in_* to out_*.
module exp_range_reduce #(
   parameter int unsigned LN2_Q16 = 45426,
   parameter int unsigned K_MAX   = 20
) (
   input logic               clk,
   input logic               rst,
   exp_range_reduce_if.slave bus
);

   localparam logic [4:0]  k_max_c = 5'(K_MAX);
   localparam logic [17:0] ln2_c   = 18'(LN2_Q16);

   logic        s1_valid;
   logic [17:0] s1_xe;
   logic [4:0]  s1_k;
   logic        s1_ovf;
   logic [17:0] s1_p;

   logic        s2_valid;
   logic [4:0]  out_k_q;
   logic [17:0] out_r_q;
   logic        out_ovf_q;

   logic        s1_adv;
   logic        in_ready;
   logic        in_xfer;
   logic        in_ovf;
   logic [4:0]  in_ksel;

   always_comb begin
      s1_adv   = s1_valid & (~s2_valid | bus.out_ready);
      in_ready = ~s1_valid | s1_adv;
      in_xfer  = bus.in_valid & in_ready;
      in_ovf   = (bus.in_k == 5'd0) | (bus.in_k > k_max_c);
      in_ksel  = in_ovf ? 5'd0 : bus.in_k;
   end

   // The residual of a legal argument always fits in 18 signed bits, so only the low
   // 18 bits of x and k*ln2 are kept; modular subtraction then yields r exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_xe    <= '0;
         s1_k     <= '0;
         s1_ovf   <= 1'b0;
         s1_p     <= '0;
      end else begin
         if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_xe    <= 18'({bus.in_data, 5'b0});
            s1_k     <= in_ksel;
            s1_ovf   <= in_ovf;
            s1_p     <= 18'(in_ksel) * ln2_c;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         out_k_q   <= '0;
         out_r_q   <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         if (s1_adv) begin
            s2_valid  <= 1'b1;
            out_k_q   <= s1_k;
            out_r_q   <= s1_ovf ? 18'd0 : (s1_xe - s1_p);
            out_ovf_q <= s1_ovf;
         end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid;
   assign bus.out_k     = out_k_q;
   assign bus.out_r     = out_r_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_exp_range_reduce.sv
// Bench for exp_range_reduce: directed cases plus a random sweep, checked against an
// arithmetic model of r = x*65536 - k*45426 and an in-flight item queue.
module tb_exp_range_reduce;

   typedef struct {
      logic [4:0]  k;
      logic [17:0] r;
      logic        ovf;
      int          age;
   } item_t;

   logic clk;
   logic rst;
   exp_range_reduce_if bus ();

   exp_range_reduce dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    total = 0;
   int    bad = 0;
   item_t q[$];
   item_t last;
   item_t pend_item;
   logic  pend_push;
   logic  pend_pop;
   int    npop;
   int    nacc;
   logic  saw_stall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic item_t model(input logic [14:0] x, input logic [4:0] k);
      item_t it;
      int    rr;
      it.ovf = (k == 5'd0) || (k > 5'd20);
      it.k   = it.ovf ? 5'd0 : k;
      rr     = it.ovf ? 0 : int'(x) * 32 - int'(it.k) * 45426;
      it.r   = 18'(rr);
      it.age = 0;
      return it;
   endfunction

   // Integer-select golden stage: k = max(1, floor(x/ln2)), or k = 0 beyond K_MAX.
   task automatic gen_input(output logic [14:0] x, output logic [4:0] k);
      int kk;
      if ($urandom_range(0, 7) == 0) begin
         if ($urandom_range(0, 1) == 0) begin
            x = 15'($urandom_range(29811, 32767));
            k = 5'd0;
         end else begin
            x = 15'($urandom);
            k = 5'($urandom_range(21, 31));
         end
      end else begin
         x  = 15'($urandom_range(0, 29810));
         kk = (int'(x) * 32) / 45426;
         if (kk < 1) kk = 1;
         k  = 5'(kk);
      end
   endtask

   // An accepted item sits in stage 1 for one edge and is visible from the next edge on;
   // only a full pipeline (two items) can refuse input, and then only while stalled.
   task automatic cycle(input logic v, input logic [14:0] x, input logic [4:0] k, input logic ordy);
      logic exp_rdy;
      logic exp_ov;
      int   rs;
      @(posedge clk);
      if (pend_pop) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (pend_push) q.push_back(pend_item);
      pend_pop  = 1'b0;
      pend_push = 1'b0;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = x;
      bus.in_k      = k;
      bus.out_ready = ordy;
      #1;
      exp_rdy = (q.size() < 2) || ordy;
      exp_ov  = (q.size() > 0) && (q[0].age >= 1);
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (!bus.in_ready) saw_stall = 1'b1;
      if (exp_ov) begin
         check("out_k", 32'(bus.out_k), 32'(q[0].k));
         check("out_r", 32'(bus.out_r), 32'(q[0].r));
         check("out_ovf", 32'(bus.out_ovf), 32'(q[0].ovf));
         if (!q[0].ovf) begin
            rs = int'($signed(bus.out_r));
            check("r_range", 32'(rs >= -45426 && rs < 45426), 32'd1);
         end
         if (ordy) begin
            pend_pop = 1'b1;
            last     = q[0];
            npop++;
         end
      end else begin
         check("hold_k", 32'(bus.out_k), 32'(last.k));
         check("hold_r", 32'(bus.out_r), 32'(last.r));
         check("hold_ovf", 32'(bus.out_ovf), 32'(last.ovf));
      end
      if (v && exp_rdy) begin
         pend_push = 1'b1;
         pend_item = model(x, k);
         nacc++;
      end
   endtask

   task automatic rst_pulse();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      q.delete();
      pend_push = 1'b0;
      pend_pop  = 1'b0;
      last      = '{k: 5'd0, r: 18'd0, ovf: 1'b0, age: 0};
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_r", 32'(bus.out_r), 32'd0);
      check("rst_out_k", 32'(bus.out_k), 32'd0);
      check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
   endtask

   initial begin
      logic [14:0] x;
      logic [4:0]  k;
      int          n0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_k      = '0;
      bus.out_ready = 1'b1;
      pend_push     = 1'b0;
      pend_pop      = 1'b0;
      npop          = 0;
      nacc          = 0;
      saw_stall     = 1'b0;
      @(posedge clk);
      rst_pulse();

      cycle(1'b1, 15'h0800, 5'd1, 1'b1);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      check("single_valid", 32'(bus.out_valid), 32'd1);
      check("single_k", 32'(bus.out_k), 32'd1);
      check("single_r", 32'(bus.out_r), 32'h04E8E);
      check("single_ovf", 32'(bus.out_ovf), 32'd0);

      cycle(1'b1, 15'h0000, 5'd1, 1'b1);
      cycle(1'b1, 15'h1000, 5'd2, 1'b1);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      check("neg_r", 32'(bus.out_r), 32'h34E8E);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      check("two_r", 32'(bus.out_r), 32'h09D1C);
      check("two_k", 32'(bus.out_k), 32'd2);

      cycle(1'b1, 15'h7000, 5'd0, 1'b1);
      cycle(1'b1, 15'h7000, 5'd21, 1'b1);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      check("ovf0_flag", 32'(bus.out_ovf), 32'd1);
      check("ovf0_k", 32'(bus.out_k), 32'd0);
      check("ovf0_r", 32'(bus.out_r), 32'd0);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      check("ovf21_flag", 32'(bus.out_ovf), 32'd1);
      check("ovf21_k", 32'(bus.out_k), 32'd0);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);

      n0        = npop;
      nacc      = 0;
      saw_stall = 1'b0;
      for (int c = 0; c < 16; c++) begin
         gen_input(x, k);
         cycle(nacc < 6, x, k, !(c >= 3 && c <= 7));
      end
      check("bp_stall_seen", 32'(saw_stall), 32'd1);
      check("bp_count", 32'(npop - n0), 32'd6);

      gen_input(x, k);
      cycle(1'b1, x, k, 1'b1);
      gen_input(x, k);
      cycle(1'b1, x, k, 1'b1);
      rst_pulse();
      cycle(1'b1, 15'h1000, 5'd2, 1'b1);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      check("post_rst_valid", 32'(bus.out_valid), 32'd1);
      check("post_rst_r", 32'(bus.out_r), 32'h09D1C);

      for (int c = 0; c < 800; c++) begin
         gen_input(x, k);
         cycle($urandom_range(0, 9) < 7, x, k, $urandom_range(0, 9) < 7);
      end
      for (int c = 0; c < 20 && (q.size() > 0 || pend_push || pend_pop); c++)
         cycle(1'b0, 15'h0000, 5'd0, 1'b1);
      check("drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
